// File: rtl/key_led_mode_ctrl.sv
// Key-driven LED pattern controller: four keys select the mode, step speed and
// pause state of a 4-LED rotate/blink pattern stepped from a divided base tick.
module key_led_mode_ctrl #(
  parameter int unsigned TICK_BASE = 10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keyflag,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       running
);

  localparam int unsigned TW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICK_BASE - 1);

  typedef enum logic [1:0] {
    ModeHold  = 2'd0,
    ModeRotL  = 2'd1,
    ModeRotR  = 2'd2,
    ModeBlink = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [1:0]    speed_q, speed_d;
  logic          running_q, running_d;
  logic [3:0]    led_q, led_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    step_q, step_d;

  logic [3:0] pat, pat_d;
  logic [2:0] step_last;
  logic       base_tick, step_ev, spd_up, spd_dn, resume, clear;

  // Pattern is kept active-high internally; the LED register holds its inverse.
  assign pat = ~led_q;

  always_comb begin
    base_tick = running_q && (tick_q == TickMax);
    step_last = 3'd7 >> speed_q;
    step_ev   = base_tick && (step_q == step_last);
    spd_up    = keyflag[1] && !keyflag[2] && (speed_q != 2'd3);
    spd_dn    = keyflag[2] && !keyflag[1] && (speed_q != 2'd0);
    resume    = keyflag[3] && !running_q;
    clear     = keyflag[0] || spd_up || spd_dn || resume;

    mode_d    = keyflag[0] ? mode_e'(mode_q + 2'd1) : mode_q;
    running_d = running_q ^ keyflag[3];
    speed_d   = speed_q;
    if (spd_up) speed_d = speed_q + 2'd1;
    if (spd_dn) speed_d = speed_q - 2'd1;

    tick_d = tick_q;
    step_d = step_q;
    if (clear) begin
      tick_d = '0;
      step_d = '0;
    end else if (base_tick) begin
      tick_d = '0;
      step_d = step_ev ? 3'd0 : step_q + 3'd1;
    end else if (running_q) begin
      tick_d = tick_q + TW'(1);
    end

    // A mode change takes priority over a coincident step.
    pat_d = pat;
    if (keyflag[0]) begin
      case (mode_d)
        ModeRotL, ModeRotR: if (pat == 4'b0000 || pat == 4'b1111) pat_d = 4'b0001;
        ModeBlink:          pat_d = 4'b1111;
        default:            pat_d = pat;
      endcase
    end else if (step_ev) begin
      case (mode_q)
        ModeRotL:  pat_d = {pat[2:0], pat[3]};
        ModeRotR:  pat_d = {pat[0], pat[3:1]};
        ModeBlink: pat_d = ~pat;
        default:   pat_d = pat;
      endcase
    end
    led_d = ~pat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ModeHold;
      speed_q   <= 2'd0;
      running_q <= 1'b1;
      led_q     <= 4'b1111;
      tick_q    <= '0;
      step_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      running_q <= running_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign speed   = speed_q;
  assign running = running_q;

endmodule
